// File: rtl/fractal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fractal_pkg                                                |
// | Brief    : Shared widths, default raster size and pixel types.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fractal_pkg;

    localparam int c_rgb_width  = 24;
    localparam int c_pix_width  = 8;
    localparam int c_x_width    = 11;
    localparam int c_def_width  = 1920;
    localparam int c_def_height = 1080;
    localparam int c_pal_depth  = 2 ** c_pix_width;

    typedef logic [c_rgb_width-1:0] rgb_t;
    typedef logic [c_pix_width-1:0] pix_t;

    function automatic rgb_t grey(input pix_t d);
        return {d, d, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fractal_palette_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fractal_palette_ram                                        |
// | Brief    : 256x24 palette, one write port, read-first registered read.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fractal_palette_ram
    import fractal_pkg::*;
(
    input  logic clk,
    input  logic i_we,
    input  pix_t i_waddr,
    input  rgb_t i_wdata,
    input  logic i_re,
    input  pix_t i_raddr,
    output rgb_t o_rdata
);

    rgb_t r_mem [c_pal_depth];
    rgb_t r_rdata;

    // Non-blocking read of r_mem gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fractal_colormap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fractal_colormap                                           |
// | Brief    : Iteration-count to RGB palette mapper with line checker.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fractal_colormap
    import fractal_pkg::*;
#(
    parameter int WIDTH  = c_def_width,
    parameter int HEIGHT = c_def_height
)(
    input  logic        aclk,
    input  logic        areset,
    input  pix_t        s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output rgb_t        m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        pal_we,
    input  pix_t        pal_addr,
    input  rgb_t        pal_wdata,
    input  logic        cfg_bypass,
    input  logic        err_clear,
    output logic [1:0]  status_err,
    output logic [15:0] frame_count
);

    if (WIDTH < 2 || WIDTH > 2 ** c_x_width || HEIGHT < 1) begin : g_bad_params
        $error("fractal_colormap: unsupported WIDTH/HEIGHT");
    end

    localparam logic [c_x_width-1:0] c_x_last = c_x_width'(WIDTH - 1);

    logic                 w_ce;
    logic                 w_accept;
    rgb_t                 w_pal_rdata;
    logic                 r_s1_valid;
    logic                 r_s1_user;
    logic                 r_s1_last;
    logic                 r_s1_bypass;
    pix_t                 r_s1_pix;
    logic                 r_m_valid;
    rgb_t                 r_m_data;
    logic                 r_m_user;
    logic                 r_m_last;
    logic [c_x_width-1:0] r_x;
    logic [c_x_width-1:0] w_x_cur;
    logic [c_x_width-1:0] w_x_next;
    logic                 w_check;
    logic                 r_synced;
    logic [1:0]           r_err;
    logic [1:0]           w_err_set;
    logic [15:0]          r_frames;

    assign w_ce     = !r_m_valid || m_axis_tready;
    assign w_accept = s_axis_tvalid && w_ce;

    fractal_palette_ram u_palette (
        .clk     (aclk),
        .i_we    (pal_we),
        .i_waddr (pal_addr),
        .i_wdata (pal_wdata),
        .i_re    (w_ce),
        .i_raddr (s_axis_tdata),
        .o_rdata (w_pal_rdata)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1_valid <= 1'b0;
            r_m_valid  <= 1'b0;
        end else if (w_ce) begin
            r_s1_valid <= s_axis_tvalid;
            r_m_valid  <= r_s1_valid;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_ce) begin
            r_s1_user   <= s_axis_tuser;
            r_s1_last   <= s_axis_tlast;
            r_s1_bypass <= cfg_bypass;
            r_s1_pix    <= s_axis_tdata;
            r_m_data    <= r_s1_bypass ? grey(r_s1_pix) : w_pal_rdata;
            r_m_user    <= r_s1_user;
            r_m_last    <= r_s1_last;
        end
    end

    // Errors are suppressed until the first tuser after reset re-aligns x.
    always_comb begin
        w_x_cur   = s_axis_tuser ? '0 : r_x;
        w_check   = s_axis_tuser || r_synced;
        w_x_next  = w_x_cur + 1'b1;
        w_err_set = 2'b00;
        if (s_axis_tlast) begin
            w_x_next     = '0;
            w_err_set[0] = w_check && (w_x_cur != c_x_last);
        end else if (w_x_cur == c_x_last) begin
            w_x_next     = '0;
            w_err_set[1] = w_check;
        end
        if (!w_accept) begin
            w_err_set = 2'b00;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_x      <= '0;
            r_synced <= 1'b0;
            r_err    <= 2'b00;
            r_frames <= 16'd0;
        end else begin
            if (w_accept) begin
                r_x <= w_x_next;
                if (s_axis_tuser) begin
                    r_synced <= 1'b1;
                    r_frames <= r_frames + 16'd1;
                end
            end
            r_err <= (err_clear ? 2'b00 : r_err) | w_err_set;
        end
    end

    assign s_axis_tready = w_ce;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tuser  = r_m_user;
    assign m_axis_tlast  = r_m_last;
    assign status_err    = r_err;
    assign frame_count   = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_fractal_colormap.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fractal_colormap                                        |
// | Brief    : Scoreboard bench for fractal_colormap on a 16x4 raster.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_fractal_colormap;

    localparam int c_w = 16;
    localparam int c_h = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [23:0] pal_wdata = '0;
    logic        cfg_bypass = 1'b0;
    logic        err_clear = 1'b0;
    logic [1:0]  status_err;
    logic [15:0] frame_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        rnd_ready = 1'b0;
    logic [25:0] sb [$];
    logic [23:0] model_pal [256];
    logic        mon_stalled = 1'b0;
    logic [25:0] mon_held = '0;

    always #5 aclk = ~aclk;

    fractal_colormap #(.WIDTH(c_w), .HEIGHT(c_h)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pal_we        (pal_we),
        .pal_addr      (pal_addr),
        .pal_wdata     (pal_wdata),
        .cfg_bypass    (cfg_bypass),
        .err_clear     (err_clear),
        .status_err    (status_err),
        .frame_count   (frame_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int f, input int x, input int y);
        return 8'((x * 7 + y * 29 + f * 61) & 255);
    endfunction

    // Caller is at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] d, input logic u, input logic l);
        int   waited;
        logic acc;
        waited = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            #4;
            acc = s_axis_tready;
            if (acc) sb.push_back({cfg_bypass ? {d, d, d} : model_pal[d], u, l});
            @(negedge aclk);
            if (acc) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: beat %0h never accepted", d);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge aclk);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        s_axis_tvalid = 1'b0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge aclk);
            waited++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d beats still outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic send_frame(input int f);
        for (int y = 0; y < c_h; y++) begin
            for (int x = 0; x < c_w; x++) begin
                send(pat(f, x, y), (x == 0 && y == 0), (x == c_w - 1));
                if (x == 5 && y == 1) idle(1);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            m_axis_tready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            #2;
            if (mon_stalled)
                check("hold_stable", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                      32'({1'b1, mon_held}));
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h with no beat outstanding", m_axis_tdata);
                end else begin
                    check("pixel", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(sb.pop_front()));
                end
            end
            mon_stalled = m_axis_tvalid && !m_axis_tready;
            mon_held    = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge aclk);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd1);
        check("rst_status_err", 32'(status_err), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        areset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            pal_we    = 1'b1;
            pal_addr  = 8'(i);
            pal_wdata = {8'(i), ~8'(i), 8'(i) ^ 8'h55};
            model_pal[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h55};
            @(negedge aclk);
        end
        pal_we = 1'b0;

        // Full-throughput frame
        send_frame(0);
        drain();
        check("frame_count_1", 32'(frame_count), 32'd1);
        check("err_after_frame", 32'(status_err), 32'd0);

        // Backpressured frame
        rnd_ready = 1'b1;
        send_frame(1);
        drain();
        rnd_ready = 1'b0;
        @(negedge aclk);
        check("frame_count_2", 32'(frame_count), 32'd2);
        check("err_after_stall_frame", 32'(status_err), 32'd0);

        // Greyscale bypass, switched off part way through the line
        cfg_bypass = 1'b1;
        send(8'hA7, 1'b1, 1'b0);
        for (int x = 1; x < c_w; x++) begin
            cfg_bypass = (x < 8);
            send(8'(x * 17), 1'b0, (x == c_w - 1));
        end
        cfg_bypass = 1'b0;
        drain();
        check("err_after_bypass", 32'(status_err), 32'd0);

        // Short line
        for (int x = 0; x < 6; x++) send(8'(x), (x == 0), (x == 5));
        idle(2);
        check("err_short", 32'(status_err), 32'd1);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        @(negedge aclk);
        check("err_cleared", 32'(status_err), 32'd0);

        // Long line: no tlast at the last pixel
        for (int x = 0; x < c_w + 1; x++) send(8'(x), 1'b0, 1'b0);
        idle(2);
        check("err_long", 32'(status_err), 32'd2);

        // Clear coincident with a short-line set: set wins, long flag clears
        err_clear = 1'b1;
        send(8'h33, 1'b0, 1'b1);
        err_clear = 1'b0;
        idle(2);
        check("err_set_wins", 32'(status_err), 32'd1);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        drain();
        check("err_cleared_2", 32'(status_err), 32'd0);

        // Read-first collision on palette address 5
        pal_we    = 1'b1;
        pal_addr  = 8'd5;
        pal_wdata = 24'h123456;
        send(8'd5, 1'b0, 1'b0);
        pal_we = 1'b0;
        model_pal[5] = 24'h123456;
        send(8'd5, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a frame
        send(8'd10, 1'b1, 1'b0);
        send(8'd11, 1'b0, 1'b0);
        send(8'd12, 1'b0, 1'b0);
        areset = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        sb.delete();
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        for (int x = 0; x < 3; x++) send(8'(x + 40), 1'b0, (x == 2));
        send_frame(2);
        drain();
        check("post_rst_frame_count", 32'(frame_count), 32'd1);
        check("post_rst_err", 32'(status_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
